mem_sequencer: RTL and testbench
================================

Name: mem_sequencer

Overview:
- Bus initiator that drives one write/read port of the tape/program RAM: the master side of the memory's single-port interface.
- Supports three commands: clear memory to zero, load a byte stream into consecutive addresses, and dump consecutive addresses out as a byte stream.
- Used at boot and for debug, before and after the CPU core owns the memory port (the external mux is not part of this block).
- The memory side matches the RAM contract: combinational read of the addressed word; write on the rising clock edge when the write enable is high.

Parameters:
- c_addr_width, 8: memory address width; depth = 2**c_addr_width.
- c_data_width, 8: memory and stream data width.

Ports:
- i_clock, input, 1: single clock; all state updates on the rising edge.
- i_reset_n, input, 1: synchronous, active-low reset.
- i_cmd_clear, input, 1: start clear; sampled only in IDLE.
- i_cmd_load, input, 1: start load; sampled only in IDLE.
- i_cmd_dump, input, 1: start dump; sampled only in IDLE.
- i_dump_len, input, c_addr_width+1: number of words to dump; latched on start.
- i_in_valid, input, 1: load-stream byte valid.
- i_in_data, input, c_data_width: load-stream byte.
- i_in_last, input, 1: marks the final load byte.
- o_in_ready, output, 1: load-stream ready.
- o_out_valid, output, 1: dump-stream valid.
- o_out_data, output, c_data_width: dump-stream byte.
- i_out_ready, input, 1: dump-stream ready.
- o_mem_enable_in, output, 1: memory write enable.
- o_mem_addr, output, c_addr_width: memory address.
- o_mem_data, output, c_data_width: memory write data.
- i_mem_data, input, c_data_width: memory read data (combinational from o_mem_addr).
- o_busy, output, 1: high in any state other than IDLE.
- o_done, output, 1: one-cycle pulse on command completion.
- o_count, output, c_addr_width+1: words written or emitted by the last command.

Behaviour:
- Reset (i_reset_n low at an edge): state IDLE, address counter 0, o_count 0, latched length 0.
  - All outputs 0: o_out_valid, o_out_data, o_done, o_busy, o_in_ready, o_mem_enable_in, o_mem_data.
  - Reset aborts any command mid-operation. No further writes occur after the reset edge.
- States: IDLE, CLEAR, LOAD, DUMP, DONE.
- IDLE:
  - Command priority is clear > load > dump. Simultaneous commands start only the highest.
  - On the edge a command is seen: address counter cleared to 0, o_count cleared to 0, i_dump_len latched when dumping.
  - Commands asserted while busy are ignored.
- o_mem_addr always equals the address counter.
- CLEAR:
  - o_mem_enable_in = 1 and o_mem_data = 0 every cycle.
  - The counter increments each cycle. The write of the last address (2**c_addr_width-1) is followed by DONE.
  - Total 2**c_addr_width cycles in CLEAR; o_count = 2**c_addr_width.
- LOAD:
  - o_in_ready = 1. o_mem_enable_in = i_in_valid (combinational). o_mem_data = i_in_data.
  - On each accepted byte: counter +1, o_count +1.
  - Exit to DONE after accepting a byte with i_in_last, or after writing the last address (full).
  - At full, later bytes are not accepted; o_in_ready is 0 outside LOAD.
- DUMP:
  - If the latched length is 0, go to DONE immediately with no output.
  - Output register loads i_mem_data whenever (!o_out_valid || i_out_ready) and words remain. On each load: o_out_valid = 1, counter +1.
  - o_out_data is held stable while o_out_valid && !i_out_ready.
  - o_count increments on each handshake (o_out_valid && i_out_ready).
  - DONE follows the handshake of the final word; o_out_valid drops to 0 that edge.
  - Length is clamped to 2**c_addr_width. The address wraps only if the length is exactly the depth, and then it ends at the wrap.
  - A sustained i_out_ready gives 1 word per cycle, with first valid 1 cycle after entering DUMP.
- DONE: o_done = 1 for exactly one cycle, o_busy = 1, then IDLE. o_count holds until the next command starts.
- o_mem_enable_in = 0 in IDLE, DUMP and DONE.

Test Plan:
- Reset then i_cmd_clear pulse with c_addr_width=8 → 256 consecutive writes of 0 at addr 0..255; o_done one cycle later; o_count=256; memory model all zero.
- i_cmd_load, stream 0x2B,0x2D,0x3E with i_in_valid gaps, last on 0x3E → mem[0..2]=2B,2D,3E; exactly 3 write-enable cycles; o_count=3; o_done pulse.
- Load of 300 bytes without i_in_last → 256 writes; o_in_ready low after byte 256; DONE reached; o_count=256.
- After the load above, dump with i_dump_len=3 and i_out_ready toggled 1,0,0,1,1 → outputs 2B,2D,3E in order; o_out_data stable while stalled; o_count=3.
- i_cmd_dump with i_dump_len=0 → no o_out_valid; o_done 2 cycles after the command; i_cmd_clear and i_cmd_load asserted together → only clear runs.
- Deassert i_reset_n midway through load (after 5 bytes) → next edge: IDLE, o_mem_enable_in=0, o_busy=0, o_count=0; mem[0..4] retained, no further writes.

Source files
------------

// File: rtl/mem_sequencer.sv
// Boot/debug master for the single-port program RAM. It can clear the RAM to
// zero, load a byte stream into consecutive addresses, or dump a range back out.
module mem_sequencer #(
  parameter int c_addr_width = 8,
  parameter int c_data_width = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_cmd_clear,
  input  logic                    i_cmd_load,
  input  logic                    i_cmd_dump,
  input  logic [c_addr_width:0]   i_dump_len,
  input  logic                    i_in_valid,
  input  logic [c_data_width-1:0] i_in_data,
  input  logic                    i_in_last,
  output logic                    o_in_ready,
  output logic                    o_out_valid,
  output logic [c_data_width-1:0] o_out_data,
  input  logic                    i_out_ready,
  output logic                    o_mem_enable_in,
  output logic [c_addr_width-1:0] o_mem_addr,
  output logic [c_data_width-1:0] o_mem_data,
  input  logic [c_data_width-1:0] i_mem_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [c_addr_width:0]   o_count
);

  localparam logic [c_addr_width:0] c_depth = {1'b1, {c_addr_width{1'b0}}};

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DUMP, DONE} state_t;

  state_t                  state;
  logic [c_addr_width-1:0] addr;
  logic [c_addr_width:0]   len_q;
  logic [c_addr_width:0]   issued;
  logic [c_addr_width:0]   cnt_inc;
  logic                    hs;
  logic                    ld;
  logic                    addr_last;

  assign cnt_inc   = o_count + 1'b1;
  assign addr_last = &addr;
  assign hs        = o_out_valid && i_out_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign ld        = (!o_out_valid || i_out_ready) && (issued < len_q);

  assign o_mem_addr      = addr;
  assign o_in_ready      = (state == LOAD);
  assign o_mem_enable_in = (state == CLEAR) || ((state == LOAD) && i_in_valid);
  assign o_mem_data      = (state == LOAD) ? i_in_data : '0;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      addr        <= '0;
      len_q       <= '0;
      issued      <= '0;
      o_count     <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_clear || i_cmd_load || i_cmd_dump) begin
            addr    <= '0;
            issued  <= '0;
            o_count <= '0;
            o_busy  <= 1'b1;
          end
          if (i_cmd_clear) begin
            state <= CLEAR;
          end else if (i_cmd_load) begin
            state <= LOAD;
          end else if (i_cmd_dump) begin
            state <= DUMP;
            len_q <= (i_dump_len > c_depth) ? c_depth : i_dump_len;
          end
        end
        CLEAR: begin
          addr    <= addr + 1'b1;
          o_count <= cnt_inc;
          if (addr_last) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        LOAD: begin
          if (i_in_valid) begin
            addr    <= addr + 1'b1;
            o_count <= cnt_inc;
            if (i_in_last || addr_last) begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (len_q == '0) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            if (ld) begin
              o_out_data  <= i_mem_data;
              o_out_valid <= 1'b1;
              addr        <= addr + 1'b1;
              issued      <= issued + 1'b1;
            end else if (hs) begin
              o_out_valid <= 1'b0;
            end
            if (hs) begin
              o_count <= cnt_inc;
              if (cnt_inc == len_q) begin
                state  <= DONE;
                o_done <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: RAM model, vector tables for the load and
// stalled-dump sequences, hand-written sequences for clear, full load and reset.
module tb_mem_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_clear, cmd_load, cmd_dump;
  logic [8:0] dump_len;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       mem_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy, done;
  logic [8:0] count;

  logic [7:0] mem [0:255];
  int         wr_cnt = 0;
  int         n_cmp  = 0;
  int         n_err  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end
  assign mem_rdata = mem[mem_addr];

  mem_sequencer #(.c_addr_width(8), .c_data_width(8)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_cmd_clear(cmd_clear), .i_cmd_load(cmd_load), .i_cmd_dump(cmd_dump),
    .i_dump_len(dump_len),
    .i_in_valid(in_valid), .i_in_data(in_data), .i_in_last(in_last), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_mem_enable_in(mem_en), .o_mem_addr(mem_addr), .o_mem_data(mem_wdata),
    .i_mem_data(mem_rdata),
    .o_busy(busy), .o_done(done), .o_count(count)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       last;
    logic [7:0] exp_addr;
  } ld_vec_t;

  typedef struct {
    logic       rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_done;
  } dp_vec_t;

  ld_vec_t ld_tab [6];
  dp_vec_t dp_tab [7];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  initial begin
    int base;
    int nz;

    ld_tab[0] = '{1'b1, 8'h2B, 1'b0, 8'd0};
    ld_tab[1] = '{1'b0, 8'h00, 1'b0, 8'd1};
    ld_tab[2] = '{1'b1, 8'h2D, 1'b0, 8'd1};
    ld_tab[3] = '{1'b0, 8'h00, 1'b0, 8'd2};
    ld_tab[4] = '{1'b0, 8'h00, 1'b0, 8'd2};
    ld_tab[5] = '{1'b1, 8'h3E, 1'b1, 8'd2};

    dp_tab[0] = '{1'b1, 1'b0, 8'h00, 1'b0};
    dp_tab[1] = '{1'b0, 1'b1, 8'h2B, 1'b0};
    dp_tab[2] = '{1'b0, 1'b1, 8'h2B, 1'b0};
    dp_tab[3] = '{1'b1, 1'b1, 8'h2B, 1'b0};
    dp_tab[4] = '{1'b1, 1'b1, 8'h2D, 1'b0};
    dp_tab[5] = '{1'b1, 1'b1, 8'h3E, 1'b0};
    dp_tab[6] = '{1'b1, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0; cmd_clear = 1'b0; cmd_load = 1'b0; cmd_dump = 1'b0;
    dump_len = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // zero-length dump: no output, done two edges after the command
    dump_len = 9'd0; cmd_dump = 1'b1;
    tick();
    cmd_dump = 1'b0; #1;
    chk("d0_busy", busy, 1);
    chk("d0_valid0", out_valid, 0);
    chk("d0_done_early", done, 0);
    tick();
    chk("d0_done", done, 1);
    chk("d0_valid1", out_valid, 0);
    chk("d0_count", count, 0);
    tick();
    chk("d0_done_clr", done, 0);
    chk("d0_idle", busy, 0);

    // 300-byte load with no last: stops at full
    base = wr_cnt; cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = 8'(i) ^ 8'h5A; in_last = 1'b0; #1;
      chk("full_ready", in_ready, (i < 256) ? 1 : 0);
      if (i == 256) begin
        chk("full_done", done, 1);
        chk("full_count", count, 256);
      end
      tick();
    end
    in_valid = 1'b0; #1;
    chk("full_writes", wr_cnt - base, 256);
    chk("full_idle", busy, 0);

    // over-length dump clamps to depth; a clear issued while busy is ignored
    base = wr_cnt; dump_len = 9'd300; out_ready = 1'b1; cmd_dump = 1'b1;
    tick();
    cmd_dump = 1'b0; #1;
    chk("big_first_invalid", out_valid, 0);
    tick();
    for (int k = 1; k <= 256; k++) begin
      cmd_clear = (k == 100); #1;
      chk("big_valid", out_valid, 1);
      chk("big_data", out_data, 8'(k - 1) ^ 8'h5A);
      tick();
    end
    cmd_clear = 1'b0; #1;
    chk("big_done", done, 1);
    chk("big_count", count, 256);
    chk("big_valid_drop", out_valid, 0);
    chk("big_addr_wrap", mem_addr, 0);
    chk("big_no_writes", wr_cnt - base, 0);
    tick();
    chk("big_idle", busy, 0);

    // short load with valid gaps
    base = wr_cnt; cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    foreach (ld_tab[i]) begin
      in_valid = ld_tab[i].v; in_data = ld_tab[i].d; in_last = ld_tab[i].last; #1;
      chk("ld_ready", in_ready, 1);
      chk("ld_en", mem_en, ld_tab[i].v);
      chk("ld_addr", mem_addr, ld_tab[i].exp_addr);
      chk("ld_wdata", mem_wdata, ld_tab[i].d);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; #1;
    chk("ld_done", done, 1);
    chk("ld_count", count, 3);
    chk("ld_writes", wr_cnt - base, 3);
    chk("ld_ready_off", in_ready, 0);
    chk("ld_mem0", mem[0], 8'h2B);
    chk("ld_mem1", mem[1], 8'h2D);
    chk("ld_mem2", mem[2], 8'h3E);
    chk("ld_mem3", mem[3], 8'h03 ^ 8'h5A);
    tick();

    // dump 3 with a stalled consumer
    dump_len = 9'd3; cmd_dump = 1'b1;
    tick();
    cmd_dump = 1'b0;
    foreach (dp_tab[i]) begin
      out_ready = dp_tab[i].rdy; #1;
      chk("dp_valid", out_valid, dp_tab[i].exp_v);
      if (dp_tab[i].exp_v) chk("dp_data", out_data, dp_tab[i].exp_d);
      chk("dp_done", done, dp_tab[i].exp_done);
      chk("dp_mem_en", mem_en, 0);
      tick();
    end
    chk("dp_count", count, 3);
    chk("dp_idle", busy, 0);

    // clear and load together: clear wins
    base = wr_cnt; cmd_clear = 1'b1; cmd_load = 1'b1;
    tick();
    cmd_clear = 1'b0; cmd_load = 1'b0;
    for (int i = 0; i < 256; i++) begin
      #1;
      chk("clr_addr", mem_addr, i);
      chk("clr_en", mem_en, 1);
      chk("clr_wdata", mem_wdata, 0);
      chk("clr_in_ready", in_ready, 0);
      tick();
    end
    chk("clr_done", done, 1);
    chk("clr_count", count, 256);
    chk("clr_writes", wr_cnt - base, 256);
    nz = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== 8'h00) nz++;
    chk("clr_mem_zero", nz, 0);
    tick();
    chk("clr_done_pulse", done, 0);

    // reset in the middle of a load
    base = wr_cnt; cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      tick();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_en", mem_en, 0);
    chk("mr_count", count, 0);
    chk("mr_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'hEE;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    #1;
    chk("mr_en_idle", mem_en, 0);
    chk("mr_writes", wr_cnt - base, 5);
    for (int a = 0; a < 5; a++) chk("mr_mem", mem[a], 8'hC0 + 8'(a));
    chk("mr_mem5", mem[5], 8'h00);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
